// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus arbiter: default widths, FSM state
// encoding, master indices and the lock-counter helper.
package dbus_pkg;

  localparam int unsigned DBUS_ADDR_W = 16;
  localparam int unsigned DBUS_DATA_W = 32;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int unsigned LOCK_CNT_W = 8;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  // Saturating increment so a very long lock never wraps back below LOCK_MAX.
  function automatic lock_cnt_t lock_cnt_inc(input lock_cnt_t v);
    return (v == '1) ? v : v + lock_cnt_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: a lone requester wins, a tie
// goes to the master that was not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master arbiter in front of the single-port data RAM: round-robin with
// optional bus lock, bounded lock duration and per-master read-valid tracking.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned ADDR_W   = DBUS_ADDR_W,
  parameter int unsigned DATA_W   = DBUS_DATA_W,
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wen,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wen,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam lock_cnt_t LOCK_MAX_C = lock_cnt_t'(LOCK_MAX);

  arb_state_t r_state;
  logic       r_last_gnt;
  lock_cnt_t  r_lock_cnt;
  logic       r_m0_rvalid;
  logic       r_m1_rvalid;

  logic [1:0] w_req;
  logic [1:0] w_lock;
  logic [1:0] w_rr_gnt;
  logic [1:0] w_gnt;
  logic       w_any_gnt;
  logic       w_gnt_idx;
  logic       w_owner;
  logic       w_other;
  logic       w_owner_req;
  logic       w_other_req;
  logic       w_cnt_hit;

  assign w_req  = {m1_req, m0_req};
  assign w_lock = {m1_lock, m0_lock};

  rr_pick2 u_rr_pick2 (
    .req  (w_req),
    .last (r_last_gnt),
    .gnt  (w_rr_gnt)
  );

  assign w_owner     = (r_state == ST_LOCK1) ? M_DMA : M_CPU;
  assign w_other     = ~w_owner;
  assign w_owner_req = w_req[w_owner];
  assign w_other_req = w_req[w_other];
  assign w_cnt_hit   = (r_lock_cnt >= LOCK_MAX_C);

  // While locked the owner wins outright, except for one forced hand-over
  // once the lock has run LOCK_MAX grants and the other master is waiting.
  always_comb begin
    w_gnt = '0;
    case (r_state)
      ST_IDLE: w_gnt = w_rr_gnt;
      ST_LOCK0, ST_LOCK1: begin
        if (w_owner_req && !(w_cnt_hit && w_other_req)) begin
          w_gnt[w_owner] = 1'b1;
        end else if (w_other_req) begin
          w_gnt[w_other] = 1'b1;
        end
      end
      default: w_gnt = '0;
    endcase
  end

  assign w_any_gnt = |w_gnt;
  assign w_gnt_idx = w_gnt[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (w_gnt[0]) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wen   = m0_wen;
    end else if (w_gnt[1]) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wen   = m1_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= 1'b1;
      r_lock_cnt  <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_gnt[0] & ~m0_wen;
      r_m1_rvalid <= w_gnt[1] & ~m1_wen;
      if (w_any_gnt) begin
        r_last_gnt <= w_gnt_idx;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_gnt && w_lock[w_gnt_idx]) begin
            r_state    <= w_gnt_idx ? ST_LOCK1 : ST_LOCK0;
            r_lock_cnt <= lock_cnt_t'(1);
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          // Owner requesting but not granted can only mean a forced hand-over.
          if (!w_owner_req) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end else if (w_gnt[w_owner]) begin
            if (!w_lock[w_owner]) begin
              r_state    <= ST_IDLE;
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= lock_cnt_inc(r_lock_cnt);
            end
          end else begin
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter with a small registered-read RAM model.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_wen, m0_lock, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m1_req, m1_wen, m1_lock, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  logic [31:0] ram [256];

  int tests = 0;
  int fails = 0;

  logic [9:0] pg0, pg1, pv0, pv1;

  always #5 clk = ~clk;

  dbus_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .LOCK_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wen    (m0_wen),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wen    (m1_wen),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic g0, input logic g1,
                     input logic v0, input logic v1);
    chk({tag, "_g0"}, {31'd0, m0_gnt}, {31'd0, g0});
    chk({tag, "_g1"}, {31'd0, m1_gnt}, {31'd0, g1});
    chk({tag, "_v0"}, {31'd0, m0_rvalid}, {31'd0, v0});
    chk({tag, "_v1"}, {31'd0, m1_rvalid}, {31'd0, v1});
  endtask

  task automatic drv0(input logic req, input logic [15:0] a, input logic [31:0] d,
                      input logic w, input logic l);
    m0_req = req; m0_addr = a; m0_wdata = d; m0_wen = w; m0_lock = l;
  endtask

  task automatic drv1(input logic req, input logic [15:0] a, input logic [31:0] d,
                      input logic w, input logic l);
    m1_req = req; m1_addr = a; m1_wdata = d; m1_wen = w; m1_lock = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h11] = 32'hCAFEF00D;
    drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    drv1(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // reset state
    @(negedge clk); #1;
    cyc("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", {16'd0, mem_addr}, 32'h0);
    chk("rst_wen", {31'd0, mem_wen}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // single m0 read of 0x0010
    @(negedge clk); drv0(1'b1, 16'h0010, 32'h0, 1'b0, 1'b0); #1;
    cyc("t1_c0", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_addr", {16'd0, mem_addr}, 32'h0000_0010);
    chk("t1_wen", {31'd0, mem_wen}, 32'h0);
    @(negedge clk); drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("t1_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    cyc("t1_c2", 1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the cycle after an m0 read grant drops the pending rvalid
    @(negedge clk); drv0(1'b1, 16'h0010, 32'h0, 1'b0, 1'b0); #1;
    cyc("rr_gnt", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    chk("rr_pre", {31'd0, m0_rvalid}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rr_now", {31'd0, m0_rvalid}, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    cyc("rr_rel0", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    cyc("rr_rel1", 1'b0, 1'b0, 1'b0, 1'b0);

    // both masters read continuously: alternating grants, m0 wins first tie
    pg0 = 10'b00_0001_0101; pg1 = 10'b00_0010_1010;
    pv0 = 10'b00_0010_1010; pv1 = 10'b00_0001_0100;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      drv0(1'b1, 16'h0010, 32'h0, 1'b0, 1'b0);
      drv1(1'b1, 16'h0011, 32'h0, 1'b0, 1'b0);
      #1;
      cyc($sformatf("t2_%0d", k), pg0[k], pg1[k], pv0[k], pv1[k]);
      if (k > 0) chk($sformatf("t2_rd%0d", k), rdata, pv0[k] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
    @(negedge clk);
    drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    drv1(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    #1;
    cyc("t2_end", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_end_rd", rdata, 32'hCAFEF00D);

    // lone m0 write: no rvalid
    @(negedge clk); drv0(1'b1, 16'h0030, 32'hA5A5A5A5, 1'b1, 1'b0); #1;
    cyc("w0", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("w0_wen", {31'd0, mem_wen}, 32'h1);
    chk("w0_wdata", mem_wdata, 32'hA5A5A5A5);
    @(negedge clk); drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("w0_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // m1 locked writes while m0 waits; m0 granted when m1 lets go
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      drv0(1'b1, 16'h0010, 32'h0, 1'b0, 1'b0);
      drv1(1'b1, 16'h0020, 32'h12345678, 1'b1, 1'b1);
      #1;
      cyc($sformatf("t3_%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t3_addr%0d", k), {16'd0, mem_addr}, 32'h0000_0020);
      chk($sformatf("t3_wd%0d", k), mem_wdata, 32'h12345678);
      chk($sformatf("t3_wen%0d", k), {31'd0, mem_wen}, 32'h1);
    end
    @(negedge clk); drv1(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("t3_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("t3_rv", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_rd", rdata, 32'hDEADBEEF);
    @(negedge clk); drv0(1'b1, 16'h0020, 32'h0, 1'b0, 1'b0); #1;
    cyc("t3_chk_g", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("t3_chk_v", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_mem20", rdata, 32'h12345678);

    // lone m1 read back of the m0 write
    @(negedge clk); drv1(1'b1, 16'h0030, 32'h0, 1'b0, 1'b0); #1;
    cyc("m1rd_g", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drv1(1'b0, 16'h0, 32'h0, 1'b0, 1'b0); #1;
    cyc("m1rd_v", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("m1rd_d", rdata, 32'hA5A5A5A5);

    // m0 locked, m1 (lock ignored) waiting: 4 m0 grants then one forced hand-over
    pg0 = 10'b01_1110_1111; pg1 = 10'b10_0001_0000;
    pv0 = 10'b11_1101_1110; pv1 = 10'b00_0010_0000;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      drv0(1'b1, 16'h0010, 32'h0, 1'b0, 1'b1);
      drv1(1'b1, 16'h0011, 32'h0, 1'b0, 1'b1);
      #1;
      cyc($sformatf("t4_%0d", k), pg0[k], pg1[k], pv0[k], pv1[k]);
      if (k > 0) chk($sformatf("t4_rd%0d", k), rdata, pv0[k] ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
    @(negedge clk);
    drv0(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    drv1(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
    #1;
    cyc("t4_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // idle bus
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      cyc($sformatf("idle_%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("idle_wen%0d", k), {31'd0, mem_wen}, 32'h0);
      chk($sformatf("idle_addr%0d", k), {16'd0, mem_addr}, 32'h0);
      chk($sformatf("idle_wd%0d", k), mem_wdata, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
